// File: rtl/superscalar_pkg.sv
// Definitions shared across the 4-wide superscalar MIPS front end.
package superscalar_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between I-fetch and decode: one group of up to
// four words in, oldest four words out, flushable on redirect.
module fetch_queue
    import superscalar_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int FW    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [2:0]               fetch_count,
    input  logic [31:0]              fetch_pc,
    input  logic [31:0]              fetch_instr0,
    input  logic [31:0]              fetch_instr1,
    input  logic [31:0]              fetch_instr2,
    input  logic [31:0]              fetch_instr3,
    output logic                     fetch_ready,
    output logic [3:0]               dec_valid,
    output logic [31:0]              dec_instr0,
    output logic [31:0]              dec_instr1,
    output logic [31:0]              dec_instr2,
    output logic [31:0]              dec_instr3,
    output logic [31:0]              dec_pc0,
    output logic [31:0]              dec_pc1,
    output logic [31:0]              dec_pc2,
    output logic [31:0]              dec_pc3,
    input  logic [2:0]               dec_take,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    count;
    logic [31:0]    fetch_instr [FETCH_WIDTH];
    logic           push;
    logic [2:0]     take_clamped;
    logic [2:0]     n;
    logic [2:0]     m;
    fetch_entry_t   slot [FETCH_WIDTH];

    assign fetch_instr[0] = fetch_instr0;
    assign fetch_instr[1] = fetch_instr1;
    assign fetch_instr[2] = fetch_instr2;
    assign fetch_instr[3] = fetch_instr3;

    // Room is judged on the registered count only; same-cycle pops earn no credit.
    assign fetch_ready = (count <= (AW+1)'(DEPTH - FW));
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign occupancy   = count;

    always_comb begin
        n            = 3'd0;
        take_clamped = (dec_take > 3'(FW)) ? 3'(FW) : dec_take;
        m            = take_clamped;
        if (push) begin
            n = (fetch_count > 3'(FW)) ? 3'(FW) : fetch_count;
        end
        if ((AW+1)'(take_clamped) > count) begin
            m = count[2:0];
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(m);
            tail  <= tail + AW'(n);
            count <= count + (AW+1)'(n) - (AW+1)'(m);
        end
    end

    // NOTE: storage has no reset; slots beyond count are masked, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FW; i++) begin
            if (3'(i) < n) begin
                mem[tail + AW'(i)] <= '{instr: fetch_instr[i], pc: fetch_pc + 32'(4 * i)};
            end
        end
    end

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
        assign dec_valid[g] = (count > (AW+1)'(g));
        assign slot[g]      = dec_valid[g] ? mem[head + AW'(g)]
                                           : '{instr: NOP_INSTR, pc: 32'h0};
    end

    assign dec_instr0 = slot[0].instr;
    assign dec_instr1 = slot[1].instr;
    assign dec_instr2 = slot[2].instr;
    assign dec_instr3 = slot[3].instr;
    assign dec_pc0    = slot[0].pc;
    assign dec_pc1    = slot[1].pc;
    assign dec_pc2    = slot[2].pc;
    assign dec_pc3    = slot[3].pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [2:0]  fetch_count = 3'd0;
    logic [31:0] fetch_pc = 32'h0;
    logic [31:0] fi [4];
    logic        fetch_ready;
    logic [3:0]  dec_valid;
    logic [31:0] dec_instr0, dec_instr1, dec_instr2, dec_instr3;
    logic [31:0] dec_pc0, dec_pc1, dec_pc2, dec_pc3;
    logic [2:0]  dec_take = 3'd0;
    logic [4:0]  occupancy;
    logic [31:0] di [4];
    logic [31:0] dp [4];

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    ent_t model_q [$];

    initial for (int i = 0; i < 4; i++) fi[i] = 32'h0;

    fetch_queue #(.DEPTH(DEPTH), .FW(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_count(fetch_count), .fetch_pc(fetch_pc),
        .fetch_instr0(fi[0]), .fetch_instr1(fi[1]), .fetch_instr2(fi[2]), .fetch_instr3(fi[3]),
        .fetch_ready(fetch_ready), .dec_valid(dec_valid),
        .dec_instr0(dec_instr0), .dec_instr1(dec_instr1), .dec_instr2(dec_instr2), .dec_instr3(dec_instr3),
        .dec_pc0(dec_pc0), .dec_pc1(dec_pc1), .dec_pc2(dec_pc2), .dec_pc3(dec_pc3),
        .dec_take(dec_take), .occupancy(occupancy)
    );

    assign di[0] = dec_instr0;
    assign di[1] = dec_instr1;
    assign di[2] = dec_instr2;
    assign di[3] = dec_instr3;
    assign dp[0] = dec_pc0;
    assign dp[1] = dec_pc1;
    assign dp[2] = dec_pc2;
    assign dp[3] = dec_pc3;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue as an ordered list of {instr, pc} entries.
    always @(posedge clk or negedge reset_n) begin
        int m;
        int n;
        bit accept;
        if (!reset_n || flush) begin
            model_q.delete();
        end else begin
            accept = fetch_valid && (DEPTH - model_q.size() >= 4);
            m = (dec_take > 4) ? 4 : int'(dec_take);
            if (m > model_q.size()) m = model_q.size();
            n = (fetch_count > 4) ? 4 : int'(fetch_count);
            repeat (m) void'(model_q.pop_front());
            if (accept) begin
                for (int i = 0; i < n; i++) model_q.push_back('{fi[i], fetch_pc + 32'(4 * i)});
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_valid;
        if (cmp_en) begin
            exp_valid = 4'b0000;
            for (int i = 0; i < 4; i++) exp_valid[i] = (model_q.size() > i);
            check("occupancy", 32'(occupancy), 32'(model_q.size()));
            check("dec_valid", 32'(dec_valid), 32'(exp_valid));
            check("fetch_ready", 32'(fetch_ready), 32'(DEPTH - model_q.size() >= 4));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("dec_instr%0d", i), di[i], (i < model_q.size()) ? model_q[i].instr : 32'h0);
                check($sformatf("dec_pc%0d", i), dp[i], (i < model_q.size()) ? model_q[i].pc : 32'h0);
            end
        end
    end

    task automatic drive(input logic fv, input logic [2:0] fc, input logic [31:0] pc,
                         input logic [2:0] take, input logic fl);
        fetch_valid = fv;
        fetch_count = fc;
        fetch_pc    = pc;
        dec_take    = take;
        flush       = fl;
        for (int i = 0; i < 4; i++) fi[i] = ~(pc + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        fetch_count = 3'd0;
        dec_take    = 3'd0;
        flush       = 1'b0;
    endtask

    task automatic cycle(input logic fv, input logic [2:0] fc, input logic [31:0] pc,
                         input logic [2:0] take, input logic fl);
        drive(fv, fc, pc, take, fl);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cmp_en = 1'b1;

        check("reset occupancy", 32'(occupancy), 32'd0);
        check("reset dec_valid", 32'(dec_valid), 32'd0);
        check("reset fetch_ready", 32'(fetch_ready), 32'd1);
        check("reset dec_instr0", dec_instr0, 32'h0);
        check("reset dec_pc3", dec_pc3, 32'h0);

        // First group; no bypass while it is being offered.
        drive(1, 4, 32'h0040_0000, 0, 0);
        #1 check("no bypass dec_valid", 32'(dec_valid), 32'd0);
        tick();
        check("first dec_valid", 32'(dec_valid), 32'hF);
        check("first dec_pc0", dec_pc0, 32'h0040_0000);
        check("first dec_pc1", dec_pc1, 32'h0040_0004);
        check("first dec_pc2", dec_pc2, 32'h0040_0008);
        check("first dec_pc3", dec_pc3, 32'h0040_000C);
        check("first dec_instr0", dec_instr0, ~32'h0040_0000);
        check("first occupancy", 32'(occupancy), 32'd4);

        // Fill to DEPTH.
        cycle(1, 4, 32'h0040_0010, 0, 0);
        check("fill8 ready", 32'(fetch_ready), 32'd1);
        cycle(1, 4, 32'h0040_0020, 0, 0);
        check("fill12 ready", 32'(fetch_ready), 32'd1);
        cycle(1, 4, 32'h0040_0030, 0, 0);
        check("fill16 ready", 32'(fetch_ready), 32'd0);
        check("fill16 occupancy", 32'(occupancy), 32'd16);
        cycle(1, 4, 32'h0040_0040, 0, 0);
        check("full reject occupancy", 32'(occupancy), 32'd16);
        check("full reject dec_pc0", dec_pc0, 32'h0040_0000);

        // Drain to 9, then flush with a group and a pop offered.
        cycle(0, 0, 0, 4, 0);
        cycle(0, 0, 0, 3, 0);
        check("drain occupancy", 32'(occupancy), 32'd9);
        check("drain dec_pc0", dec_pc0, 32'h0040_001C);
        cycle(1, 4, 32'h0060_0000, 4, 1);
        check("flush occupancy", 32'(occupancy), 32'd0);
        check("flush dec_valid", 32'(dec_valid), 32'd0);
        check("flush dec_instr0", dec_instr0, 32'h0);
        check("flush dec_instr1", dec_instr1, 32'h0);
        check("flush dec_instr2", dec_instr2, 32'h0);
        check("flush dec_instr3", dec_instr3, 32'h0);
        check("flush fetch_ready", 32'(fetch_ready), 32'd1);
        cycle(0, 0, 0, 0, 0);
        check("flush dropped group", 32'(occupancy), 32'd0);

        // Simultaneous push and pop at occupancy 6.
        cycle(1, 4, 32'h0000_2000, 0, 0);
        cycle(1, 2, 32'h0000_3000, 0, 0);
        check("pp pre occupancy", 32'(occupancy), 32'd6);
        cycle(1, 3, 32'h0000_4000, 2, 0);
        check("pp occupancy", 32'(occupancy), 32'd7);
        check("pp dec_pc0", dec_pc0, 32'h0000_2008);
        check("pp dec_instr0", dec_instr0, ~32'h0000_2008);
        check("pp dec_pc2", dec_pc2, 32'h0000_3000);

        // Over-request at occupancy 2, then at empty.
        cycle(0, 0, 0, 4, 0);
        cycle(0, 0, 0, 1, 0);
        check("over pre occupancy", 32'(occupancy), 32'd2);
        cycle(0, 0, 0, 4, 0);
        check("over occupancy", 32'(occupancy), 32'd0);
        check("over dec_valid", 32'(dec_valid), 32'd0);
        cycle(0, 0, 0, 3, 0);
        check("empty take occupancy", 32'(occupancy), 32'd0);

        // Full boundary at DEPTH-3: no credit for a same-cycle pop.
        cycle(1, 4, 32'h0000_6000, 0, 0);
        cycle(1, 4, 32'h0000_6010, 0, 0);
        cycle(1, 4, 32'h0000_6020, 0, 0);
        cycle(1, 1, 32'h0000_6030, 0, 0);
        check("b13 occupancy", 32'(occupancy), 32'd13);
        check("b13 fetch_ready", 32'(fetch_ready), 32'd0);
        cycle(1, 4, 32'h0000_7000, 4, 0);
        check("b13 pop-only occupancy", 32'(occupancy), 32'd9);
        check("b13 dec_pc0", dec_pc0, 32'h0000_6010);
        cycle(0, 0, 0, 0, 1);

        // Walk head to 14 with two entries, then push across the index wrap.
        cycle(1, 4, 32'h0000_5000, 0, 0);
        cycle(1, 4, 32'h0000_5010, 4, 0);
        cycle(1, 4, 32'h0000_5020, 4, 0);
        cycle(1, 4, 32'h0000_1000, 4, 0);
        check("wrap pre dec_pc0", dec_pc0, 32'h0000_1000);
        cycle(0, 0, 0, 2, 0);
        check("wrap h14 dec_pc0", dec_pc0, 32'h0000_1008);
        check("wrap h14 dec_valid", 32'(dec_valid), 32'h3);
        cycle(1, 4, 32'h0000_1010, 0, 0);
        check("wrap dec_pc0", dec_pc0, 32'h0000_1008);
        check("wrap dec_pc1", dec_pc1, 32'h0000_100C);
        check("wrap dec_pc2", dec_pc2, 32'h0000_1010);
        check("wrap dec_pc3", dec_pc3, 32'h0000_1014);
        check("wrap dec_instr2", dec_instr2, ~32'h0000_1010);
        cycle(1, 0, 32'h0000_9990, 2, 0);
        check("wrap pop occupancy", 32'(occupancy), 32'd4);
        check("wrap pop dec_pc0", dec_pc0, 32'h0000_1010);
        check("wrap pop dec_pc3", dec_pc3, 32'h0000_101C);

        // PC arithmetic wraps past the top of the address space.
        cycle(1, 3, 32'hFFFF_FFF8, 0, 0);
        cycle(0, 0, 0, 4, 0);
        check("pcwrap dec_pc0", dec_pc0, 32'hFFFF_FFF8);
        check("pcwrap dec_pc1", dec_pc1, 32'hFFFF_FFFC);
        check("pcwrap dec_pc2", dec_pc2, 32'h0000_0000);
        check("pcwrap dec_valid", 32'(dec_valid), 32'h7);

        // Asynchronous reset in the middle of a cycle.
        #2 reset_n = 1'b0;
        #1;
        check("async occupancy", 32'(occupancy), 32'd0);
        check("async dec_valid", 32'(dec_valid), 32'd0);
        check("async fetch_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycle(1, 2, 32'h0000_8000, 0, 0);
        check("post reset occupancy", 32'(occupancy), 32'd2);
        check("post reset dec_pc1", dec_pc1, 32'h0000_8004);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
